// File: rtl/mux_scan_ctrl_if.sv
// Handshake and mux-side bus of the scan sequencer.
// The master drives the word and the mux return; the slave is the sequencer.
interface mux_scan_ctrl_if;
    logic [3:0] word_in;
    logic       valid_in;
    logic       ready_out;
    logic [3:0] d_out;
    logic [1:0] sel_out;
    logic       y_in;
    logic       strobe_out;
    logic [3:0] rx_word_out;
    logic       done_out;
    logic       err_out;

    modport master (
        output word_in, valid_in, y_in,
        input  ready_out, d_out, sel_out, strobe_out, rx_word_out, done_out, err_out
    );

    modport slave (
        input  word_in, valid_in, y_in,
        output ready_out, d_out, sel_out, strobe_out, rx_word_out, done_out, err_out
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Drives an accepted word into the 4:1 mux, steps the select with a fixed dwell,
// samples the mux output back and flags any mismatch with the original word.
module mux_scan_ctrl #(
    parameter int DWELL   = 5,
    parameter int DWELL_W = 3
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    mux_scan_ctrl_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [DWELL_W-1:0] CNT_LAST = DWELL_W'(DWELL - 1);

    logic [1:0]         state;
    logic [DWELL_W-1:0] cnt;
    logic [1:0]         sel;
    logic [3:0]         d_word;
    logic [3:0]         rx;
    logic [3:0]         rx_word;
    logic               err;
    logic               last_dwell;
    logic [3:0]         rx_final;

    // Sample point is the final cycle of each dwell, giving the mux DWELL-1 cycles to settle.
    assign last_dwell = (state == ST_SCAN) && (cnt == CNT_LAST);
    assign rx_final   = {bus.y_in, rx[2:0]};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            sel     <= 2'd0;
            d_word  <= 4'd0;
            rx      <= 4'd0;
            rx_word <= 4'd0;
            err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.valid_in) begin
                        d_word <= bus.word_in;
                        sel    <= 2'd0;
                        cnt    <= '0;
                        rx     <= 4'd0;
                        err    <= 1'b0;
                        state  <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (last_dwell) begin
                        rx[sel] <= bus.y_in;
                        cnt     <= '0;
                        sel     <= sel + 2'd1;
                        // rx_word is only published here, so an aborted scan never exposes partial bits.
                        if (sel == 2'd3) begin
                            rx_word <= rx_final;
                            err     <= (rx_final != d_word);
                            state   <= ST_DONE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready_out   = (state == ST_IDLE);
    assign bus.done_out    = (state == ST_DONE);
    assign bus.strobe_out  = last_dwell;
    assign bus.d_out       = d_word;
    assign bus.sel_out     = sel;
    assign bus.rx_word_out = rx_word;
    assign bus.err_out     = err;
endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencing stage upstream of the 4:1 mux (`mux_4to1_case`). It accepts 4-bit words over a valid/ready handshake and drives the word onto the mux data inputs. It then steps the mux select through 0..3, holding each select for a programmable dwell. At the end of each dwell it samples the mux output back, reassembles the word and flags any mismatch.

## Interface
Parameters:
- `DWELL`, default 5: clock cycles each select value is held. Legal range is 1..2^DWELL_W.
- `DWELL_W`, default 3: width of the dwell counter. It must be able to hold DWELL-1.

Ports:
- `clk_in`  input  1  single clock, rising edge.
- `rst_n_in`  input  1  reset, asynchronous and active-low.
- `word_in`  input  4  word to scan.
- `valid_in`  input  1  `word_in` is valid.
- `ready_out`  output  1  block can accept a word.
- `d_out`  output  4  to mux `d_in`; holds the accepted word.
- `sel_out`  output  2  to mux `sel_in`.
- `y_in`  input  1  from mux `y_out`; combinational path through the mux.
- `strobe_out`  output  1  high in each cycle in which `y_in` is sampled.
- `rx_word_out`  output  4  reassembled word; bit i is the value sampled at sel=i.
- `done_out`  output  1  one-cycle pulse when a scan completes.
- `err_out`  output  1  `rx_word_out` differs from `d_out`; valid from `done_out` onward.

## Operation
- There are three states: IDLE, SCAN and DONE.
- **IDLE**
  - `ready_out`=1.
  - Accept occurs on `valid_in` && `ready_out` at a rising edge. At that edge: `d_out`<=`word_in`, `sel_out`<=0, dwell counter `cnt`<=0, internal rx register<=0, `err_out`<=0, and the state moves to SCAN.
  - `valid_in` is ignored outside IDLE.
- **SCAN**
  - `ready_out`=0.
  - `cnt` increments each cycle.
  - When `cnt`==DWELL-1:
    - `strobe_out`=1, decoded combinationally from state and `cnt`.
    - At the edge, `y_in` is written to rx bit[`sel_out`] and `cnt`<=0.
    - If `sel_out`<3: `sel_out`<=`sel_out`+1.
    - If `sel_out`==3: `sel_out`<=0 (wrap), `rx_word_out`<={`y_in`, rx[2:0]}, `err_out`<=({`y_in`, rx[2:0]} != `d_out`), and the state moves to DONE.
- **DONE**
  - `done_out`=1 for exactly this one cycle; `ready_out`=0.
  - The state moves unconditionally to IDLE.
- Retention in IDLE:
  - `d_out`, `rx_word_out` and `err_out` hold until the next accept.
  - `sel_out` stays at 0.
- Counter and select widths:
  - `cnt` is DWELL_W bits.
  - `sel_out` is 2 bits; its wrap 3->0 is natural modulo arithmetic.
- With DWELL=1, `strobe_out` is high in every SCAN cycle.

## Timing
- Reset values (asynchronous, applied immediately on `rst_n_in` low): state=IDLE, `ready_out`=1, `d_out`=0, `sel_out`=0, `cnt`=0, `strobe_out`=0, `rx_word_out`=0, `done_out`=0, `err_out`=0.
- Reset during SCAN or DONE aborts the scan: no `done_out` pulse is produced and no partial word is exposed.
- Schedule, counting the accept edge as edge 0:
  - SCAN occupies cycles 1..4·DWELL.
  - sel=i is held during cycles i·DWELL+1..(i+1)·DWELL.
  - The strobe for sel=i falls in cycle (i+1)·DWELL.
- `done_out` is high in cycle 4·DWELL+1. `ready_out` returns to 1 in cycle 4·DWELL+2.
- Throughput is one word per 4·DWELL+2 cycles when `valid_in` is held high; this is 22 cycles at DWELL=5.
- `d_out` and `sel_out` are registered, so the mux output settles within the same cycle. Sampling at the last dwell cycle gives DWELL-1 cycles of margin.
- `valid_in` held across a busy period: the word is accepted at the first edge at which `ready_out`=1. Exactly one accept happens per IDLE visit.

## Test plan
- **Reset.** Assert `rst_n_in`=0 mid-cycle.
  - Expect all outputs at reset values immediately and `ready_out`=1.
  - Release reset, hold `valid_in`=0 for 10 cycles. Expect no `strobe_out` and no `done_out`.
- **Single scan, DWELL=5, mux in loop.** Accept word 4'b1011.
  - Expect `sel_out` = 0,1,2,3 for 5 cycles each.
  - Expect `strobe_out` in cycles 5, 10, 15 and 20.
  - Expect `done_out` in cycle 21, with `rx_word_out`=4'b1011 and `err_out`=0.
  - Expect `ready_out`=1 in cycle 22.
- **Back-to-back.** Hold `valid_in`=1 with words 4'h0, then 4'hF, then 4'h6.
  - Expect accepts at edges 0, 22 and 44.
  - Expect each `rx_word_out` to match its word and `err_out`=0 each time.
- **Fault injection.** Force `y_in`=0 and scan 4'b0100.
  - Expect `rx_word_out`=4'b0000 and `err_out`=1 at `done_out`.
  - Expect both values held through IDLE until the next accept clears `err_out`.
- **DWELL=1 build.** Scan 4'b1001.
  - Expect `strobe_out` high in cycles 1–4 and `done_out` in cycle 5.
  - Expect `rx_word_out`=4'b1001.
- **Reset mid-scan.** Assert `rst_n_in` low at cycle 12 of a scan of 4'hA.
  - Expect no `done_out` pulse, and `rx_word_out`=0 and `ready_out`=1 after reset.
  - Then scan 4'h3 to completion correctly.
